fir_mac_sequencer: RTL and testbench

- Control FSM for a time-multiplexed FIR datapath: one shared multiplier-accumulator (MAC), one coefficient ROM and one circular sample buffer.
- Handshakes with the input sample source.
- Per accepted sample: writes the sample into the buffer, then steps the MAC through all NUM_TAPS products, then flags the finished output word.
- Replaces the free-running 16-cycle output-enable counter with a sequenced, sample-driven schedule.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_tap_counter.sv | 46 ++++
 rtl/fir_mac_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC sequencer slice.
package fir_pkg;

  localparam int NUM_TAPS_DEF = 16;
  localparam int ADDR_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter for the MAC phase. It exposes its next value so the owner
// can decode registered outputs one cycle ahead.
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] count_nxt,
  output logic              last
);

  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] count_nxt_s;

  // Next count: clear has priority over enable.
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = {ADDR_W{1'b0}};
    end else if (en) begin
      count_nxt_s = count_r + ADDR_W'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {ADDR_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign last      = (count_r == ADDR_W'(NUM_TAPS - 1));

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sample-driven control FSM for a time-multiplexed FIR MAC datapath.
// Optional FIR_OUT_HOLD_EN adds out_ready back-pressure on the finished word.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
`ifdef FIR_OUT_HOLD_EN
  input  logic              out_ready,
`endif
  output logic              sample_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  output logic              busy
);

  fir_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_W-1:0] tap_s, tap_nxt_s;
  logic              tap_last_s;

  logic              sample_ready_s, wr_en_s, acc_clr_s, acc_en_s, out_valid_s, busy_s;
  logic [ADDR_W-1:0] wr_addr_s, smp_addr_s, coef_addr_s;

  fir_tap_counter #(
    .NUM_TAPS (NUM_TAPS),
    .ADDR_W   (ADDR_W)
  ) u_tap (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_r == LOAD),
    .en        (state_r == MAC),
    .count     (tap_s),
    .count_nxt (tap_nxt_s),
    .last      (tap_last_s)
  );

  // Next-state and write-pointer logic.
  always_comb begin
    state_nxt_s  = state_r;
    wr_ptr_nxt_s = wr_ptr_r;
    case (state_r)
      IDLE: begin
        if (sample_valid) state_nxt_s = LOAD;
        else              state_nxt_s = IDLE;
      end
      LOAD: state_nxt_s = MAC;
      MAC: begin
        if (tap_last_s) state_nxt_s = DONE;
        else            state_nxt_s = MAC;
      end
      DONE: begin
`ifdef FIR_OUT_HOLD_EN
        if (out_ready) begin
          state_nxt_s  = IDLE;
          wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1'b1);
        end else begin
          state_nxt_s  = DONE;
        end
`else
        state_nxt_s  = IDLE;
        wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1'b1);
`endif
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from next-cycle state so the outputs themselves are registers.
  always_comb begin
    sample_ready_s = (state_nxt_s == IDLE);
    busy_s         = (state_nxt_s != IDLE);
    wr_en_s        = (state_nxt_s == LOAD);
    acc_en_s       = (state_nxt_s == MAC);
    out_valid_s    = (state_nxt_s == DONE);
    acc_clr_s      = 1'b0;
    wr_addr_s      = {ADDR_W{1'b0}};
    smp_addr_s     = {ADDR_W{1'b0}};
    coef_addr_s    = {ADDR_W{1'b0}};
    if (state_nxt_s == LOAD) begin
      wr_addr_s = wr_ptr_nxt_s;
    end else begin
      wr_addr_s = {ADDR_W{1'b0}};
    end
    if (state_nxt_s == MAC) begin
      coef_addr_s = tap_nxt_s;
      smp_addr_s  = wr_ptr_nxt_s - tap_nxt_s;
      acc_clr_s   = (tap_nxt_s == {ADDR_W{1'b0}});
    end else begin
      coef_addr_s = {ADDR_W{1'b0}};
      smp_addr_s  = {ADDR_W{1'b0}};
      acc_clr_s   = 1'b0;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {ADDR_W{1'b0}};
      sample_ready <= 1'b1;
      busy         <= 1'b0;
      wr_en        <= 1'b0;
      acc_en       <= 1'b0;
      acc_clr      <= 1'b0;
      out_valid    <= 1'b0;
      wr_addr      <= {ADDR_W{1'b0}};
      smp_addr     <= {ADDR_W{1'b0}};
      coef_addr    <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      sample_ready <= sample_ready_s;
      busy         <= busy_s;
      wr_en        <= wr_en_s;
      acc_en       <= acc_en_s;
      acc_clr      <= acc_clr_s;
      out_valid    <= out_valid_s;
      wr_addr      <= wr_addr_s;
      smp_addr     <= smp_addr_s;
      coef_addr    <= coef_addr_s;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: a cycle-count schedule model per
// accepted sample, directed scenarios, then random sample_valid traffic.
module tb_fir_mac_sequencer;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic          out_ready;
  logic          sample_ready, wr_en, acc_clr, acc_en, out_valid, busy;
  logic [AW-1:0] wr_addr, smp_addr, coef_addr;

  int checks   = 0;
  int failures = 0;

  // Model: m_cnt = cycles since acceptance (0 = idle), m_ptr = buffer slot for next sample.
  int m_cnt = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.NUM_TAPS(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
`ifdef FIR_OUT_HOLD_EN
    .out_ready    (out_ready),
`endif
    .sample_ready (sample_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .smp_addr     (smp_addr),
    .coef_addr    (coef_addr),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit mac;
    int tap;
    mac = (m_cnt >= 2) && (m_cnt <= N + 1);
    tap = m_cnt - 2;
    chk("sample_ready", 32'(sample_ready), 32'(m_cnt == 0));
    chk("busy",         32'(busy),         32'(m_cnt != 0));
    chk("wr_en",        32'(wr_en),        32'(m_cnt == 1));
    chk("wr_addr",      32'(wr_addr),      (m_cnt == 1) ? 32'(m_ptr) : 32'd0);
    chk("acc_en",       32'(acc_en),       32'(mac));
    chk("acc_clr",      32'(acc_clr),      32'(mac && tap == 0));
    chk("coef_addr",    32'(coef_addr),    mac ? 32'(tap) : 32'd0);
    chk("smp_addr",     32'(smp_addr),     mac ? 32'((m_ptr - tap + N) % N) : 32'd0);
    chk("out_valid",    32'(out_valid),    32'(m_cnt == N + 2));
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (m_cnt == 0) begin
      if (sample_valid) m_cnt = 1;
    end else if (m_cnt == N + 2) begin
      m_cnt = 0;
      m_ptr = (m_ptr + 1) % N;
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    out_ready    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outputs();
    repeat (10) step();

    // single pulse
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (N + 4) step();

    // held high: 3 samples then 17 more, wrapping the write pointer
    sample_valid = 1'b1;
    repeat (20 * (N + 3)) step();
    sample_valid = 1'b0;
    repeat (N + 4) step();

    // asynchronous reset in the middle of MAC at tap 7
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 40 && m_cnt != 9; i++) step();
    chk("coef_addr_before_reset", 32'(coef_addr), 32'd7);
    #2 reset = 1'b1;
    #1;
    m_cnt = 0;
    m_ptr = 0;
    check_outputs();
    #1 reset = 1'b0;
    @(negedge clk);
    repeat (3) step();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (N + 4) step();

    // random traffic, including sample_valid toggling while busy
    repeat (400) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      step();
    end
    sample_valid = 1'b0;
    repeat (N + 4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
